// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Time-multiplexed scan controller for the irrigation status display.
//   N_DIGITS common-anode digits share one 4-bit code -> 7-segment decoder.
//   Each digit slot starts with BLANK cycles where every digit is off, which
//   suppresses ghosting. The slot then lights its digit for the rest of the
//   DIV cycles. Codes and blink mask are snapshotted once per frame so that
//   one frame always shows one coherent set of values.
//
// Ports
//   CLK         system clock, rising edge
//   RST         synchronous reset, active-high (has priority over ENABLE)
//   ENABLE      scan enable; 0 = display dark and scan restarts
//   CODES       digit codes, digit i = CODES[4i+3:4i]
//   BLINK_MASK  1 = digit i blinks
//   C           code for the decoder, selected from the snapshot only
//   DIG_EN      active-low digit enables, at most one low at a time
//   FRAME       one-cycle pulse on the last cycle of each frame
module display_scan_ctrl #(
  parameter int N_DIGITS     = 4,
  parameter int DIV          = 50000,
  parameter int BLANK        = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ENABLE,
  input  logic [4*N_DIGITS-1:0]   CODES,
  input  logic [N_DIGITS-1:0]     BLINK_MASK,
  output logic [3:0]              C,
  output logic [N_DIGITS-1:0]     DIG_EN,
  output logic                    FRAME
);

  localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_BLANK  = CNT_W'(BLANK);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST  = FCNT_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0]        cnt, cntNext;
  logic [IDX_W-1:0]        idx, idxNext;
  logic [4*N_DIGITS-1:0]   snapCodes, snapCodesNext;
  logic [N_DIGITS-1:0]     snapMask, snapMaskNext;
  logic                    loadPend, loadPendNext;
  logic [FCNT_W-1:0]       fcnt, fcntNext;
  logic                    phase, phaseNext;
  logic [N_DIGITS-1:0]     digEnReg, digEnNext;
  logic                    frameEnd;

  assign frameEnd = (cnt == CNT_LAST) && (idx == IDX_LAST);

  // FRAME is a pure decode of the current count and the live enable.
  assign FRAME = ENABLE && frameEnd;

  // C only muxes registers, so it moves only when idx or the snapshot moves.
  assign C = snapCodes[{idx, 2'b00} +: 4];

  assign DIG_EN = digEnReg;

  // Next-state logic for counters, snapshot, blink and digit enables.
  always_comb begin
    cntNext       = cnt;
    idxNext       = idx;
    snapCodesNext = snapCodes;
    snapMaskNext  = snapMask;
    loadPendNext  = loadPend;
    fcntNext      = fcnt;
    phaseNext     = phase;
    digEnNext     = {N_DIGITS{1'b1}};

    if (!ENABLE) begin
      // Dark and parked at the start of slot 0; the snapshot is kept.
      cntNext      = '0;
      idxNext      = '0;
      loadPendNext = 1'b1;
      fcntNext     = '0;
      phaseNext    = 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cntNext = '0;
        if (idx == IDX_LAST) begin
          idxNext = '0;
        end else begin
          idxNext = idx + IDX_W'(1);
        end
      end else begin
        cntNext = cnt + CNT_W'(1);
        idxNext = idx;
      end

      // Load on the first enabled edge and at every frame boundary.
      if (loadPend || frameEnd) begin
        snapCodesNext = CODES;
        snapMaskNext  = BLINK_MASK;
        loadPendNext  = 1'b0;
      end else begin
        snapCodesNext = snapCodes;
        snapMaskNext  = snapMask;
      end

      if (frameEnd) begin
        if (fcnt == FCNT_LAST) begin
          fcntNext  = '0;
          phaseNext = ~phase;
        end else begin
          fcntNext  = fcnt + FCNT_W'(1);
        end
      end else begin
        fcntNext = fcnt;
      end
    end

    // Enables are derived from next-state so the registered DIG_EN lines up
    // with the cnt/idx held during the same cycle.
    if (ENABLE && (cntNext >= CNT_BLANK) && !(snapMaskNext[idxNext] && phaseNext)) begin
      digEnNext[idxNext] = 1'b0;
    end else begin
      digEnNext = {N_DIGITS{1'b1}};
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt       <= '0;
      idx       <= '0;
      snapCodes <= '0;
      snapMask  <= '0;
      loadPend  <= 1'b1;
      fcnt      <= '0;
      phase     <= 1'b0;
      digEnReg  <= {N_DIGITS{1'b1}};
    end else begin
      cnt       <= cntNext;
      idx       <= idxNext;
      snapCodes <= snapCodesNext;
      snapMask  <= snapMaskNext;
      loadPend  <= loadPendNext;
      fcnt      <= fcntNext;
      phase     <= phaseNext;
      digEnReg  <= digEnNext;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with DIV=8, BLANK=2, N_DIGITS=4,
// BLINK_FRAMES=2. Outputs are sampled 1 time unit after each rising edge.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] codes = 16'h0000;
  logic [3:0]  blinkMask = 4'b0000;
  logic [3:0]  c;
  logic [3:0]  digEn;
  logic        frame;

  int checks = 0;
  int failures = 0;
  logic [3:0] prevC = 4'h0;

  display_scan_ctrl #(
    .N_DIGITS(4), .DIV(8), .BLANK(2), .BLINK_FRAMES(2)
  ) dut (
    .CLK(clk), .RST(rst), .ENABLE(enable), .CODES(codes),
    .BLINK_MASK(blinkMask), .C(c), .DIG_EN(digEn), .FRAME(frame)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Compare all outputs for one cycle plus the per-cycle invariants.
  task automatic observe(input string tag, input logic [3:0] expDig,
                         input logic [3:0] expC, input logic expFrame);
    int lows;
    chk4({tag, "_digen"}, digEn, expDig);
    chk4({tag, "_c"}, c, expC);
    chk4({tag, "_frame"}, {3'b000, frame}, {3'b000, expFrame});
    lows = 0;
    for (int i = 0; i < 4; i++) if (digEn[i] === 1'b0) lows++;
    chk4({tag, "_onelow"}, {3'b000, (lows <= 1)}, 4'h1);
    if (digEn !== 4'b1111) chk4({tag, "_cstable"}, c, prevC);
    prevC = c;
  endtask

  // Run enabled scan cycles 0..n-1 from cycle 0, checking each against the
  // reference timeline. CODES switches to codesB at cycle changeAt.
  task automatic runScan(input string tag, input int n, input logic [15:0] codesA,
                         input logic [15:0] codesB, input int changeAt,
                         input logic [3:0] mask, input logic [3:0] c0);
    int slot, pos, frm;
    logic [15:0] fcodes;
    logic [3:0] eDig, eC;
    for (int k = 0; k < n; k++) begin
      frm  = k / 32;
      slot = (k / 8) % 4;
      pos  = k % 8;
      fcodes = (frm == 0) ? codesA : codesB;
      eC = (k == 0) ? c0 : fcodes[slot*4 +: 4];
      if (pos < 2) eDig = 4'b1111;
      else if (mask[slot] && (((frm / 2) % 2) == 1)) eDig = 4'b1111;
      else begin
        eDig = 4'b1111;
        eDig[slot] = 1'b0;
      end
      observe($sformatf("%s_k%0d", tag, k), eDig, eC, (k % 32) == 31);
      if (k == changeAt) codes = codesB;
      tick();
    end
  endtask

  initial begin
    // Reset for three cycles.
    rst = 1'b1;
    enable = 1'b0;
    tick(); tick(); tick();
    observe("reset", 4'b1111, 4'h0, 1'b0);

    // Basic scan over two frames with a mid-frame code change.
    rst = 1'b0;
    enable = 1'b1;
    codes = 16'h4321;
    blinkMask = 4'b0000;
    runScan("scan", 64, 16'h4321, 16'h8765, 5, 4'b0000, 4'h0);

    // Blinking digit 2 over six frames.
    rst = 1'b1;
    codes = 16'h4321;
    blinkMask = 4'b0100;
    tick();
    observe("blink_rst", 4'b1111, 4'h0, 1'b0);
    rst = 1'b0;
    runScan("blink", 192, 16'h4321, 16'h4321, -1, 4'b0100, 4'h0);

    // Disable during digit 1 ON phase, then re-enable.
    rst = 1'b1;
    blinkMask = 4'b0000;
    tick();
    rst = 1'b0;
    runScan("dis", 12, 16'h4321, 16'h4321, -1, 4'b0000, 4'h0);
    observe("dis_c12", 4'b1101, 4'h2, 1'b0);
    enable = 1'b0;
    tick();
    observe("dis_c13", 4'b1111, 4'h1, 1'b0);
    codes = 16'hABCD;
    tick();
    observe("dis_hold1", 4'b1111, 4'h1, 1'b0);
    tick();
    observe("dis_hold2", 4'b1111, 4'h1, 1'b0);
    enable = 1'b1;
    runScan("reen", 20, 16'hABCD, 16'hABCD, -1, 4'b0000, 4'h1);

    // Reset in the middle of digit 2 with ENABLE held high.
    rst = 1'b1;
    codes = 16'h4321;
    tick();
    rst = 1'b0;
    runScan("pre", 20, 16'h4321, 16'h4321, -1, 4'b0000, 4'h0);
    observe("mid_c20", 4'b1011, 4'h3, 1'b0);
    rst = 1'b1;
    codes = 16'h9876;
    tick();
    observe("mid_rst", 4'b1111, 4'h0, 1'b0);
    rst = 1'b0;
    runScan("post", 11, 16'h9876, 16'h9876, -1, 4'b0000, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
